// File: rtl/arinc429_pkg.sv
// Shared ARINC 429 definitions: word geometry, transmitter state encoding,
// and the odd-parity helper used by both the transmitter and receiver checker.
package arinc429_pkg;

    localparam int WORD_W   = 32;
    localparam int GAP_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HALF,
        NULL_HALF,
        GAP
    } tx_state_t;

    // Parity bit that makes the full 32-bit word carry an odd number of ones
    function automatic logic odd_parity(input logic [WORD_W-2:0] data);
        return ~^data;
    endfunction

    // Maps transmit sequence position to word bit: label MSB-first, then 8..31
    function automatic logic [4:0] tx_bit_index(input logic [4:0] seq);
        return (seq < 5'd8) ? (5'd7 - seq) : seq;
    endfunction

endpackage

// File: rtl/arinc429_bit_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so a load
// of N-1 yields a phase lasting exactly N cycles.
module arinc429_bit_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/arinc429_tx.sv
// ARINC 429 transmitter: accepts a 31-bit word, appends odd parity, and sends
// 32 return-to-zero bits (label MSB-first) followed by a 4-bit-time null gap.
module arinc429_tx
    import arinc429_pkg::*;
#(
    parameter int HALF_BIT_HS = 40,
    parameter int HALF_BIT_LS = 320
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [30:0] data_in,
    input  logic        speed_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx_hi,
    output logic        tx_lo,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int HMAX = (HALF_BIT_HS > HALF_BIT_LS) ? HALF_BIT_HS : HALF_BIT_LS;
    localparam int TW   = $clog2(HMAX) + 1;
    localparam int GW   = TW + $clog2(2 * GAP_BITS) + 1;

    tx_state_t         state;
    tx_state_t         state_nx;
    logic [WORD_W-1:0] word_q;
    logic [TW-1:0]     half_q;
    logic [4:0]        bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_last;
    logic              done_q;
    logic              accept;
    logic              timer_load;
    logic              timer_tc;
    logic [TW-1:0]     timer_val;
    logic              cur_bit;

    assign accept   = in_valid && (state == IDLE);
    assign gap_last = (GW'(half_q) * GW'(2 * GAP_BITS)) - GW'(1);

    // On accept the timer takes the newly selected rate; otherwise the latched one
    assign timer_val = accept
                     ? (speed_sel ? TW'(HALF_BIT_HS - 1) : TW'(HALF_BIT_LS - 1))
                     : (half_q - TW'(1));

    arinc429_bit_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and timer reload at every half-bit boundary
    always_comb begin
        state_nx   = state;
        timer_load = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx   = SEND_HALF;
                    timer_load = 1'b1;
                end
            end
            SEND_HALF: begin
                if (timer_tc) begin
                    state_nx   = NULL_HALF;
                    timer_load = 1'b1;
                end
            end
            NULL_HALF: begin
                if (timer_tc) begin
                    if (bit_cnt == 5'd31) begin
                        state_nx = GAP;
                    end else begin
                        state_nx   = SEND_HALF;
                        timer_load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == gap_last) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Word/rate capture, bit sequencing, gap counting and the done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q  <= '0;
            half_q  <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == GAP) && (state_nx == IDLE);
            if (accept) begin
                word_q  <= {odd_parity(data_in), data_in};
                half_q  <= speed_sel ? TW'(HALF_BIT_HS) : TW'(HALF_BIT_LS);
                bit_cnt <= '0;
            end else if ((state == NULL_HALF) && timer_tc && (bit_cnt != 5'd31)) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            if ((state == GAP) && (state_nx != IDLE)) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    assign cur_bit  = word_q[tx_bit_index(bit_cnt)];
    assign tx_hi    = (state == SEND_HALF) && cur_bit;
    assign tx_lo    = (state == SEND_HALF) && !cur_bit;
    assign tx_busy  = (state != IDLE);
    assign in_ready = (state == IDLE);
    assign tx_done  = done_q;

endmodule

// File: tb/tb_arinc429_tx.sv
// Directed bench for arinc429_tx: a line monitor decodes RTZ pulses back into
// words, which are scored against expectations queued when each word is driven.
module tb_arinc429_tx;

    localparam int HS = 2;
    localparam int LS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [30:0] data_in;
    logic        speed_sel;
    logic        in_valid;
    logic        in_ready;
    logic        tx_hi;
    logic        tx_lo;
    logic        tx_busy;
    logic        tx_done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int cur_h      = HS;
    int first_drive = 0;
    int done_cycle  = 0;

    logic [31:0] expq[$];
    logic [31:0] capq[$];

    int          mon_bitn = 0;
    int          mon_run  = 0;
    int          mon_null = 0;
    int          mon_pos;
    logic        mon_bit;
    logic [31:0] mon_word = '0;

    always #5 clk = ~clk;

    arinc429_tx #(
        .HALF_BIT_HS(HS),
        .HALF_BIT_LS(LS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .speed_sel (speed_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_hi     (tx_hi),
        .tx_lo     (tx_lo),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    // Cycle index, used to measure first-drive to done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Line monitor: rebuilds words from pulses and checks pulse/null widths
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_bitn = 0;
            mon_run  = 0;
            mon_null = 0;
            mon_word = '0;
        end else begin
            check("legs_exclusive", {31'b0, tx_hi & tx_lo}, 32'd0);
            if (tx_hi || tx_lo) begin
                if (mon_run == 0) begin
                    mon_bit = tx_hi;
                    if (mon_bitn == 0) first_drive = cyc;
                    else check("null_width", mon_null, cur_h);
                end
                mon_run++;
                mon_null = 0;
            end else begin
                if (mon_run != 0) begin
                    check("pulse_width", mon_run, cur_h);
                    mon_pos = (mon_bitn < 8) ? (7 - mon_bitn) : mon_bitn;
                    mon_word[mon_pos] = mon_bit;
                    mon_bitn++;
                    if (mon_bitn == 32) begin
                        capq.push_back(mon_word);
                        mon_bitn = 0;
                        mon_word = '0;
                    end
                    mon_run = 0;
                end
                mon_null++;
            end
        end
    end

    // Present one word for a single accept edge, then scramble the inputs
    task automatic applyStimulus(input logic [30:0] d, input logic s);
        data_in   = d;
        speed_sel = s;
        in_valid  = 1'b1;
        cur_h     = s ? HS : LS;
        expq.push_back({~^d, d});
        @(posedge clk); #1;
        in_valid  = 1'b0;
        data_in   = 31'($urandom);
        speed_sel = ~s;
    endtask

    task automatic waitDone(input string tag);
        bit seen = 1'b0;
        int budget = 72 * cur_h + 20;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (tx_done === 1'b1) begin
                seen = 1'b1;
                done_cycle = cyc;
            end
        end
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] c;
        logic [31:0] e;
        check({tag, "_latency"}, done_cycle - first_drive, 72 * cur_h);
        compared++;
        assert (capq.size() != 0 && expq.size() != 0) else begin
            mismatched++;
            $error("[TB] FAIL %s_word_present: captured %0d expected %0d", tag, capq.size(), expq.size());
        end
        if (capq.size() != 0 && expq.size() != 0) begin
            c = capq.pop_front();
            e = expq.pop_front();
            check({tag, "_word"}, c, e);
            check({tag, "_odd_parity"}, {31'b0, ^c}, 32'd1);
        end
    endtask

    task automatic runWord(input string tag, input logic [30:0] d, input logic s);
        applyStimulus(d, s);
        check({tag, "_first_drive"}, {31'b0, tx_hi | tx_lo}, 32'd1);
        check({tag, "_busy"}, {31'b0, tx_busy}, 32'd1);
        check({tag, "_not_ready"}, {31'b0, in_ready}, 32'd0);
        waitDone(tag);
        checkOutput(tag);
        @(posedge clk); #1;
        check({tag, "_done_single"}, {31'b0, tx_done}, 32'd0);
        check({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [30:0] wa;
        logic [30:0] wb;
        int n;
        int done_count;

        rst_n     = 1'b0;
        data_in   = '0;
        speed_sel = 1'b1;
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_busy",  {31'b0, tx_busy},  32'd0);
        check("rst_hi",    {31'b0, tx_hi},    32'd0);
        check("rst_lo",    {31'b0, tx_lo},    32'd0);
        check("rst_done",  {31'b0, tx_done},  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] all-zero word, high speed");
        runWord("zero_hs", 31'h0, 1'b1);

        $display("[TB] single bit 0 set, high speed");
        runWord("bit0_hs", 31'h0000001, 1'b1);

        $display("[TB] label 0xFF, low speed");
        runWord("ff_ls", 31'h00000FF, 1'b0);

        $display("[TB] random word, high speed");
        runWord("rand_hs", 31'($urandom), 1'b1);

        $display("[TB] back-to-back words with in_valid held");
        wa = 31'($urandom);
        wb = 31'($urandom);
        data_in   = wa;
        speed_sel = 1'b1;
        in_valid  = 1'b1;
        cur_h     = HS;
        expq.push_back({~^wa, wa});
        @(posedge clk); #1;
        data_in = wb;
        expq.push_back({~^wb, wb});
        check("b2b_busy", {31'b0, tx_busy}, 32'd1);
        waitDone("b2b_a");
        check("b2b_ready_at_done", {31'b0, in_ready}, 32'd1);
        checkOutput("b2b_a");
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_no_idle_gap", {31'b0, tx_hi | tx_lo}, 32'd1);
        check("b2b_done_single", {31'b0, tx_done}, 32'd0);
        waitDone("b2b_b");
        checkOutput("b2b_b");
        @(posedge clk); #1;

        $display("[TB] reset during bit 12");
        applyStimulus(31'h5A5A5A5, 1'b1);
        n = 0;
        while (mon_bitn != 12 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_reached_bit12", mon_bitn, 32'd12);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(expq.pop_back());
        check("rst_mid_hi",    {31'b0, tx_hi},    32'd0);
        check("rst_mid_lo",    {31'b0, tx_lo},    32'd0);
        check("rst_mid_busy",  {31'b0, tx_busy},  32'd0);
        check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        done_count = 0;
        for (int i = 0; i < 72 * HS + 20; i++) begin
            if (tx_done === 1'b1) done_count++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_done", done_count, 32'd0);
        check("rst_mid_no_word", capq.size(), 32'd0);

        $display("[TB] recovery word after reset");
        runWord("recover_hs", 31'h2AAAAAA, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
